// File: rtl/demux_4_slot.sv
// demux_4_slot: routes one word stream into four single-entry valid/ready slots, or broadcasts to all.
// Optional drain counters on stat_cnt when DEMUX_STATS_EN is defined.
module demux_4_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic              in_bcast,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3
`ifdef DEMUX_STATS_EN
  ,
  output logic [63:0]       stat_cnt
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  state_t            state_q [4];
  state_t            state_d [4];
  logic [DATA_W-1:0] data_q  [4];
  logic [DATA_W-1:0] data_d  [4];
  logic [3:0]        free, load, drain;
  always_comb begin
    for (int k = 0; k < 4; k++) out_valid[k] = state_q[k] == FULL;
  end
  // A slot can take a word if it is empty or being drained this same cycle.
  always_comb begin
    free     = ~out_valid | out_ready;
    drain    = out_valid & out_ready;
    in_ready = in_bcast ? &free : free[in_sel];
    load     = (in_valid && in_ready) ? (in_bcast ? 4'hf : 4'b0001 << in_sel) : 4'h0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = load[k] ? FULL : (drain[k] ? EMPTY : state_q[k]);
      data_d[k]  = load[k] ? in_data : data_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  always_comb begin
    for (int k = 0; k < 4; k++) cnt_d[k] = cnt_q[k] + {15'd0, drain[k]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end
  assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule

// File: tb/tb_demux_4_slot.sv
// tb_demux_4_slot: directed stimulus with per-channel expected-word queues drained by a monitor.
module tb_demux_4_slot;
  logic        clk = 0, rst_n = 1, in_valid = 0, in_bcast = 0;
  logic [1:0]  in_sel = 0;
  logic [31:0] in_data = 0;
  logic [3:0]  out_ready = 0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_STATS_EN
  logic [63:0] stat_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q [4][$];

  demux_4_slot #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] od(input int k);
    return k == 0 ? out_data0 : k == 1 ? out_data1 : k == 2 ? out_data2 : out_data3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; offers one word for a cycle and queues it if it should be accepted.
  task automatic offer(input logic [1:0] s, input logic b, input logic [31:0] d,
                       input logic exp_rdy, input string name);
    in_valid = 1; in_sel = s; in_bcast = b; in_data = d;
    @(negedge clk);
    chk(name, in_ready, exp_rdy);
    if (exp_rdy)
      for (int k = 0; k < 4; k++) if (b || k == int'(s)) exp_q[k].push_back(d);
    cyc();
    in_valid = 0; in_bcast = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain%0d: got unexpected word %0h expected none", k, od(k));
          end else chk($sformatf("drain%0d", k), od(k), exp_q[k].pop_front());
        end
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    #11;
    chk("rst_valid", out_valid, 4'b0000);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k), od(k), 0);
    rst_n = 1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk($sformatf("idle_rdy%0d", s), in_ready, 1);
    end
    in_bcast = 1;
    #1 chk("idle_rdy_bcast", in_ready, 1);
    // in_valid low must write nothing even with broadcast selected
    cyc();
    in_data = 32'hFFFF_FFFF;
    cyc();
    in_bcast = 0;
    @(negedge clk) chk("no_valid_no_write", out_valid, 4'b0000);
    // single routing and holding
    cyc();
    offer(2, 0, 32'hDEAD_BEEF, 1, "rdy_single");
    @(negedge clk);
    chk("single_valid", out_valid, 4'b0100);
    chk("single_data", out_data2, 32'hDEAD_BEEF);
    cyc();
    offer(2, 0, 32'h1111_1111, 0, "rdy_full_slot");
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 4'b0100);
      chk("hold_data", out_data2, 32'hDEAD_BEEF);
    end
    cyc();
    out_ready = 4'b0100;
    cyc();
    out_ready = 0;
    @(negedge clk) chk("single_drained", out_valid, 4'b0000);
    // back-to-back on channel 1
    cyc();
    out_ready = 4'b0010;
    for (int i = 1; i <= 8; i++) offer(1, 0, 32'(i), 1, "rdy_b2b");
    @(negedge clk);
    cyc();
    out_ready = 0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 4'b0000);
    chk("b2b_all_drained", exp_q[1].size(), 0);
    // broadcast blocked by slot 3
    cyc();
    offer(3, 0, 32'hAAAA_0003, 1, "rdy_slot3");
    offer(0, 1, 32'h1234_5678, 0, "bcast_blocked");
    @(negedge clk);
    chk("bcast_blk_valid", out_valid, 4'b1000);
    chk("bcast_blk_d3", out_data3, 32'hAAAA_0003);
    chk("bcast_blk_d0", out_data0, 0);
    chk("bcast_blk_d1", out_data1, 8);
    cyc();
    out_ready = 4'b1000;
    offer(0, 1, 32'h1234_5678, 1, "bcast_ok");
    out_ready = 0;
    @(negedge clk);
    chk("bcast_valid", out_valid, 4'b1111);
    for (int k = 0; k < 4; k++) chk($sformatf("bcast_data%0d", k), od(k), 32'h1234_5678);
    cyc();
    out_ready = 4'b1111;
    cyc();
    out_ready = 0;
    @(negedge clk) chk("bcast_drained", out_valid, 4'b0000);
    // asynchronous reset with two slots full
    cyc();
    offer(0, 0, 32'h0000_0A0A, 1, "rdy_a");
    offer(1, 0, 32'h0000_0B0B, 1, "rdy_b");
    @(negedge clk) chk("pre_rst_valid", out_valid, 4'b0011);
    cyc();
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 4'b0000);
    chk("async_rst_d0", out_data0, 0);
    chk("async_rst_d1", out_data1, 0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #3 rst_n = 1;
    cyc();
    offer(0, 0, 32'hCAFE_0000, 1, "rdy_post_rst");
    @(negedge clk);
    chk("post_rst_valid", out_valid, 4'b0001);
    chk("post_rst_d0", out_data0, 32'hCAFE_0000);
    cyc();
    out_ready = 4'b0001;
    cyc();
    out_ready = 0;
`ifdef DEMUX_STATS_EN
    rst_n = 0;
    #2 rst_n = 1;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    cyc();
    out_ready = 4'b0001; in_valid = 1; in_sel = 0; in_bcast = 0;
    for (int i = 0; i < 65537; i++) begin
      in_data = 32'(i);
      exp_q[0].push_back(32'(i));
      cyc();
    end
    in_valid = 0;
    @(negedge clk);
    cyc();
    out_ready = 0;
    @(negedge clk) chk("stat_cnt_wrap", stat_cnt, 64'h0000_0000_0000_0001);
`endif
    for (int k = 0; k < 4; k++) chk($sformatf("queue%0d_empty", k), exp_q[k].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_4_slot.md
Name: demux_4_slot

Overview:
- Inverse of the datapath selectors: takes one 32-bit word stream and distributes each word to one of four destination channels, or to all four.
- Each destination has a one-entry holding slot with a valid/ready handshake, so a stalled consumer does not corrupt data.
- Sits between a producer stage and up to four consumer stages, e.g. result fan-out to writeback, store buffer and debug taps.

Parameters:
- DATA_W, 32, width of data word and of every output channel.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  2  destination channel index 0..3; ignored when in_bcast=1.
- in_bcast  input  1  deliver the word to all four channels.
- in_data  input  DATA_W  word.
- out_valid  output  4  bit k: slot k holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- out_data0  output  DATA_W  slot 0 contents.
- out_data1  output  DATA_W  slot 1 contents.
- out_data2  output  DATA_W  slot 2 contents.
- out_data3  output  DATA_W  slot 3 contents.
- stat_cnt  output  64  only with DEMUX_STATS_EN: four 16-bit drain counters, channel k at bits [16k+15:16k].

Behaviour:
- Reset (rst_n=0, asynchronous) clears out_valid to 4'b0000 and out_data0..3 to 0. With DEMUX_STATS_EN, stat_cnt clears to 0.
- Reset mid-transfer discards every held word. There is no replay.
- Per-slot free condition, combinational: free[k] = ~out_valid[k] | out_ready[k].
- in_ready, combinational:
  - in_bcast=0: in_ready = free[in_sel].
  - in_bcast=1: in_ready = AND of free[3:0].
  - in_ready has a combinational path from out_ready and is not registered.
- Accept is in_valid & in_ready, evaluated at the rising edge.
  - Accepted word is loaded into slot in_sel, or into all four slots for a broadcast.
  - The loaded slot's out_valid is 1 the next cycle, so latency is exactly 1 cycle.
- Drain is out_valid[k] & out_ready[k]. Slot k clears out_valid[k] at the next edge unless it is loaded in that same cycle.
- Simultaneous drain and load of the same slot: the new word replaces the old one and out_valid[k] stays 1. This gives full throughput of 1 word/cycle per channel.
- Holding: while out_valid[k]=1 and out_ready[k]=0, out_data_k is frozen.
- After a drain, out_data_k keeps its last value and is don't-care to consumers.
- Slots are independent. Loading slot j never affects slot k (k≠j), except through a broadcast.
- No partial broadcast: if any slot is blocked, nothing is written and in_ready=0.
- in_valid=0 writes nothing, regardless of in_sel and in_bcast.
- Per-slot state machine, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load, whether or not a drain happens the same cycle.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - stat_cnt port exists.
  - Counter k increments by 1 on every drain of slot k.
  - 16-bit wrap-around: 16'hFFFF + 1 -> 16'h0000.
- Undefined: no stat_cnt port and no counter flops. All other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid=0000, all out_data=0, in_ready=1 for every in_sel with out_ready=0000.
- Single routing: in_sel=2, in_data=32'hDEADBEEF, out_ready=0000 -> next cycle out_valid=0100 and out_data2=DEADBEEF. A second word to sel=2 sees in_ready=0. The word holds stable 5 cycles, then out_ready[2]=1 drains it and out_valid=0000.
- Back-to-back throughput: 8 words 1..8 to sel=1 with out_ready[1] held 1 -> in_ready stays 1 every cycle and consumer 1 receives 1..8 in order on consecutive cycles.
- Broadcast blocking: slot 3 full with out_ready[3]=0, then broadcast 32'h12345678 -> in_ready=0 and no slot changes. Raise out_ready[3] -> accepted, and out_valid=1111 with all four out_data=12345678.
- Async reset mid-operation: slots 0 and 1 full, pull rst_n low between edges -> out_valid=0000 immediately. After release, a fresh word to sel=0 is accepted normally.
- DEMUX_STATS_EN: drain channel 0 exactly 65537 times -> stat_cnt[15:0]=1. Channels 1..3 remain 0.
